// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Requests a pipeline stall while busy and holds its result in DONE while EX is frozen.
module ex_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Div_Start,
  input  logic [1:0]      Div_Op,
  input  logic [XLEN-1:0] Div_Dividend,
  input  logic [XLEN-1:0] Div_Divisor,
  input  logic            Div_Flush,
  input  logic            Div_Hold,
  output logic            EX_StallReq,
  output logic [XLEN-1:0] Div_Result,
  output logic            Div_Valid,
  output logic            Div_Busy
);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_CALC = 2'b01, S_DONE = 2'b10} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvsr;
  logic [XLEN-1:0]   r_result;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_is_rem;

  logic              w_accept;
  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_res;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_sub;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic              w_last;
  logic [XLEN-1:0]   w_fin;

  function automatic logic [XLEN-1:0] f_sign_fix(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  assign w_accept   = (r_state == S_IDLE) && Div_Start && !Div_Flush;
  assign w_signed   = ~Div_Op[0];
  assign w_a_neg    = w_signed & Div_Dividend[XLEN-1];
  assign w_b_neg    = w_signed & Div_Divisor[XLEN-1];
  assign w_abs_a    = f_sign_fix(w_a_neg, Div_Dividend);
  assign w_abs_b    = f_sign_fix(w_b_neg, Div_Divisor);
  assign w_div_zero = (Div_Divisor == '0);
  // Signed most-negative / -1 overflows; RV32M defines the result rather than trapping.
  assign w_ovf      = w_signed && (Div_Dividend == {1'b1, {(XLEN-1){1'b0}}}) && (&Div_Divisor);
  assign w_special  = w_div_zero | w_ovf;
  assign w_spec_res = w_div_zero ? (Div_Op[1] ? Div_Dividend : '1)
                                 : (Div_Op[1] ? '0 : Div_Dividend);

  // One restoring step: shift next dividend bit into the partial remainder, try subtract.
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_sub     = w_shift - {1'b0, r_dvsr};
  assign w_ge      = ~w_sub[XLEN];
  assign w_rem_nxt = w_ge ? w_sub[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
  assign w_last    = (r_state == S_CALC) && (r_cnt == '0);
  assign w_fin     = r_is_rem ? f_sign_fix(r_neg_r, w_rem_nxt) : f_sign_fix(r_neg_q, w_quo_nxt);

  always_comb begin
    w_next      = r_state;
    EX_StallReq = 1'b0;
    case (r_state)
      S_IDLE: begin
        EX_StallReq = w_accept;
        if (w_accept) w_next = w_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        EX_StallReq = 1'b1;
        if (r_cnt == '0) w_next = S_DONE;
      end
      S_DONE: begin
        if (!Div_Hold) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (Div_Flush) begin
      w_next      = S_IDLE;
      EX_StallReq = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= CNT_W'(XLEN-1);
        if (w_special) r_result <= w_spec_res;
      end else if (r_state == S_CALC && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_last && !Div_Flush) r_result <= w_fin;
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rem    <= '0;
      r_quo    <= w_abs_a;
      r_dvsr   <= w_abs_b;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_is_rem <= Div_Op[1];
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
  end

  assign Div_Result = r_result;
  assign Div_Valid  = (r_state == S_DONE);
  assign Div_Busy   = (r_state != S_IDLE);

endmodule
